// File: rtl/mic_capture_scheduler.sv
// rtl/mic_capture_scheduler.sv - round-robin scheduler merging per-channel mic samples into one stream
//
// Purpose: after a start pulse and an optional blanking interval, accepts up to
// capture_len samples from NCH channels (one holding register each), arbitrates
// them round-robin onto a single registered valid/ready output and flags the
// final word with out_last.
//
// Ports:
//   clk4_8        system clock, all registers on rising edge
//   res           synchronous active-high reset
//   start         one-cycle pulse, begins a capture (ignored unless idle)
//   blank_len     cycles to ignore samples after start
//   capture_len   total words to accept across all channels
//   sample_data   NCH x DW samples, channel 0 in the LSBs
//   sample_valid  per-channel one-cycle valid pulses
//   out_data      granted sample
//   out_ch        source channel of out_data
//   out_valid     out_data/out_ch/out_last are valid
//   out_ready     sink accepts the current word
//   out_last      current word is the final word of the capture
//   busy          FSM not idle
//   done          one-cycle pulse at capture completion
//   overrun       sticky per-channel dropped-sample flags
module mic_capture_scheduler #(
    parameter int NCH = 4,
    parameter int DW  = 21,
    parameter int CW  = 16,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk4_8,
    input  logic              res,
    input  logic              start,
    input  logic [CW-1:0]     blank_len,
    input  logic [CW-1:0]     capture_len,
    input  logic [NCH*DW-1:0] sample_data,
    input  logic [NCH-1:0]    sample_valid,
    output logic [DW-1:0]     out_data,
    output logic [CHW-1:0]    out_ch,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              busy,
    output logic              done,
    output logic [NCH-1:0]    overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BLANK,
        S_CAPTURE,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t             state_q;
    logic [CW-1:0]      blank_cnt_q;
    logic [CW-1:0]      len_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [CHW-1:0]     ptr_q, ptr_d;
    logic [NCH-1:0]     full_q, full_d;
    logic [DW-1:0]      hold_q [NCH];
    logic [DW-1:0]      hold_d [NCH];
    logic [NCH-1:0]     overrun_q, overrun_d;
    logic [DW-1:0]      out_data_q, out_data_d;
    logic [CHW-1:0]     out_ch_q, out_ch_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic               busy_q;
    logic               done_q;

    logic               active;
    logic               out_free;
    logic               gnt_vld;
    logic               gnt_fire;
    logic [CHW-1:0]     gnt_idx;
    logic [CHW:0]       scan;
    logic               others_full;
    logic               last_hs;

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;

    always_comb begin
        active   = (state_q == S_CAPTURE) || (state_q == S_DRAIN);
        // The output register can take a new word if empty or emptying this cycle.
        out_free = !out_valid_q || out_ready;
        last_hs  = out_valid_q && out_ready && out_last_q;

        // Round-robin scan starting at ptr_q (the channel after the last grant).
        gnt_vld = 1'b0;
        gnt_idx = '0;
        scan    = '0;
        for (int k = 0; k < NCH; k++) begin
            scan = {1'b0, ptr_q} + (CHW+1)'(k);
            if (scan >= (CHW+1)'(NCH)) begin
                scan = scan - (CHW+1)'(NCH);
            end
            if (!gnt_vld && full_q[scan[CHW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = scan[CHW-1:0];
            end
        end
        gnt_fire = active && out_free && gnt_vld;

        others_full = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            if (full_q[i] && (CHW'(i) != gnt_idx)) begin
                others_full = 1'b1;
            end
        end

        full_d    = full_q;
        hold_d    = hold_q;
        cnt_d     = cnt_q;
        overrun_d = overrun_q;
        if (gnt_fire) begin
            full_d[gnt_idx] = 1'b0;
        end
        // Ascending channel order; the count check uses the running total so
        // simultaneous pulses beyond capture_len are dropped without overrun.
        if (state_q == S_CAPTURE) begin
            for (int i = 0; i < NCH; i++) begin
                if (sample_valid[i]) begin
                    if (full_q[i] && !(gnt_fire && (gnt_idx == CHW'(i)))) begin
                        overrun_d[i] = 1'b1;
                    end else if (cnt_d < len_q) begin
                        full_d[i] = 1'b1;
                        hold_d[i] = sample_data[i*DW +: DW];
                        cnt_d     = cnt_d + CW'(1);
                    end
                end
            end
        end

        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_last_d  = out_last_q;
        ptr_d       = ptr_q;
        if (gnt_fire) begin
            out_valid_d = 1'b1;
            out_data_d  = hold_q[gnt_idx];
            out_ch_d    = gnt_idx;
            // No loads can follow once the count is exhausted, so this word
            // is final when nothing else is left waiting.
            out_last_d  = (cnt_q == len_q) && !others_full;
            ptr_d       = (gnt_idx == CHW'(NCH-1)) ? '0 : gnt_idx + CHW'(1);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk4_8) begin
        if (res) begin
            state_q     <= S_IDLE;
            blank_cnt_q <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            ptr_q       <= '0;
            full_q      <= '0;
            overrun_q   <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            full_q      <= full_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            overrun_q   <= overrun_d;
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
            done_q      <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        len_q       <= capture_len;
                        blank_cnt_q <= blank_len;
                        cnt_q       <= '0;
                        overrun_q   <= '0;
                        ptr_q       <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= (blank_len == '0) ? S_CAPTURE : S_BLANK;
                    end
                end
                S_BLANK: begin
                    // Entered with blank_cnt_q == blank_len, so this stays blank_len cycles.
                    blank_cnt_q <= blank_cnt_q - CW'(1);
                    if (blank_cnt_q == CW'(1)) begin
                        state_q <= S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    if (cnt_q == len_q) begin
                        if (len_q == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (last_hs) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule
